// File: rtl/level_pkg.sv
// level_pkg: level range constants shared by level_ctrl and the thermometer-encoder test.
package level_pkg;
   localparam int LEVEL_W = 3;
   localparam logic [LEVEL_W-1:0] LEVEL_MAX = 3'd7;
   localparam logic [LEVEL_W-1:0] LEVEL_MIN = 3'd0;
   typedef logic [LEVEL_W-1:0] level_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, counter debounce and one-cycle press pulse on debounced rise.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic pressed
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic s1, s2, db, db_q;
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         db   <= 1'b0;
         db_q <= 1'b0;
         cnt  <= '0;
      end else begin
         s1   <= raw;
         s2   <= s1;
         db_q <= db;
         if (s2 == db) cnt <= '0;
         else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
            db  <= ~db;
            cnt <= '0;
         end else cnt <= cnt + CW'(1);
      end
   always_comb pressed = db & ~db_q;
endmodule

// File: rtl/level_ctrl.sv
// level_ctrl: debounced up/down buttons step a saturating 0..7 level.
// Define LEVEL_DECAY_EN to add an idle timer that steps the level down every DECAY_CYCLES.
module level_ctrl
   import level_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int DECAY_CYCLES    = 1000000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               btn_up,
   input  logic               btn_down,
   output logic [LEVEL_W-1:0] level,
   output logic               at_max,
   output logic               at_min,
   output logic               changed
);
   logic up_p, dn_p, decay, up_ev, dn_ev;
   level_t level_nxt;
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (.clk(clk), .rst_n(rst_n), .raw(btn_up), .pressed(up_p));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (.clk(clk), .rst_n(rst_n), .raw(btn_down), .pressed(dn_p));
`ifdef LEVEL_DECAY_EN
   localparam int TW = $clog2(DECAY_CYCLES + 1);
   logic [TW-1:0] timer;
   always_comb decay = ~(up_p | dn_p) && timer == TW'(DECAY_CYCLES - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) timer <= '0;
      else timer <= (up_p | dn_p | decay) ? '0 : timer + TW'(1);
`else
   always_comb decay = 1'b0;
`endif
   // simultaneous presses cancel; decay only fires when neither button pressed
   always_comb begin
      up_ev = up_p & ~dn_p;
      dn_ev = (dn_p & ~up_p) | decay;
      level_nxt = (up_ev && level != LEVEL_MAX) ? level + level_t'(1) :
                  (dn_ev && level != LEVEL_MIN) ? level - level_t'(1) : level;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         level   <= LEVEL_MIN;
         changed <= 1'b0;
      end else begin
         level   <= level_nxt;
         changed <= level_nxt != level;
      end
   always_comb begin
      at_max = level == LEVEL_MAX;
      at_min = level == LEVEL_MIN;
   end
endmodule

// File: tb/tb_level_ctrl.sv
// tb_level_ctrl: table-driven press vectors plus hand sequences for latency, bounce, reset and decay.
module tb_level_ctrl;
   logic clk = 1'b0, rst_n = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
   logic [2:0] level;
   logic at_max, at_min, changed;
   int n_vec = 0, n_err = 0, chg_cnt = 0;

   level_ctrl #(.DEBOUNCE_CYCLES(4), .DECAY_CYCLES(20)) dut (
      .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
      .level(level), .at_max(at_max), .at_min(at_min), .changed(changed)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit up;
      bit dn;
      logic [2:0] lvl;
      bit mx;
      bit mn;
      int chg;
   } vec_t;
   vec_t tv[24];

   task automatic step();
      @(posedge clk);
      #1;
      if (changed === 1'b1) chg_cnt++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit found;
      for (int i = 0; i < 9; i++)
         tv[i] = '{1'b1, 1'b0, (i < 7) ? 3'(i + 1) : 3'd7, i >= 6, 1'b0, (i < 7) ? 1 : 0};
      for (int i = 0; i < 9; i++)
         tv[9 + i] = '{1'b0, 1'b1, (i < 7) ? 3'(6 - i) : 3'd0, 1'b0, i >= 6, (i < 7) ? 1 : 0};
      tv[18] = '{1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1};
      tv[19] = '{1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1};
      tv[20] = '{1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1};
      tv[21] = '{1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 0};
      tv[22] = '{1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1};
      tv[23] = '{1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1};

      repeat (2) step();
      chk("rst_level", level, 0);
      chk("rst_at_min", at_min, 1);
      chk("rst_at_max", at_max, 0);
      chk("rst_changed", changed, 0);
      rst_n = 1'b1;

      chg_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         btn_up = (i % 2 == 0);
         repeat (2) step();
      end
      btn_up = 1'b0;
      repeat (15) step();
      chk("bounce_level", level, 0);
      chk("bounce_changed", chg_cnt, 0);

      btn_up = 1'b1;
      repeat (7) step();
      chk("lat_before", level, 0);
      step();
      chk("lat_level", level, 1);
      chk("lat_changed", changed, 1);
      step();
      chk("lat_pulse_end", changed, 0);
      btn_up = 1'b0;
      repeat (12) step();

      btn_up = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_level", level, 0);
      chk("async_rst_at_min", at_min, 1);
      step();
      rst_n = 1'b1;
      repeat (10) step();
      chk("held_thru_rst", level, 1);
      btn_up = 1'b0;
      repeat (12) step();

      btn_up = 1'b1;
      repeat (4) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      btn_up = 1'b0;
      chg_cnt = 0;
      repeat (15) step();
      chk("mid_rst_level", level, 0);
      chk("mid_rst_changed", chg_cnt, 0);

      for (int i = 0; i < 24; i++) begin
         chg_cnt = 0;
         btn_up = tv[i].up;
         btn_down = tv[i].dn;
         repeat (8) step();
         btn_up = 1'b0;
         btn_down = 1'b0;
         repeat (10) step();
         chk($sformatf("vec%0d_level", i), level, tv[i].lvl);
         chk($sformatf("vec%0d_flags", i), {at_max, at_min}, {tv[i].mx, tv[i].mn});
         chk($sformatf("vec%0d_changed", i), chg_cnt, tv[i].chg);
      end

      btn_up = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 12 && !found; k++) begin
         step();
         if (level === 3'd2) found = 1'b1;
      end
      btn_up = 1'b0;
      chk("idle_setup", found, 1);
`ifdef LEVEL_DECAY_EN
      repeat (19) step();
      chk("decay_hold19", level, 2);
      step();
      chk("decay_20", level, 1);
      chk("decay_changed", changed, 1);
      repeat (19) step();
      chk("decay_hold39", level, 1);
      step();
      chk("decay_40", level, 0);
      repeat (60) step();
      chk("decay_floor", level, 0);
`else
      chg_cnt = 0;
      repeat (100) step();
      chk("idle_hold", level, 2);
      chk("idle_changed", chg_cnt, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/level_ctrl.md
LEVEL_CTRL -- requirements
Module: level_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, the number of consecutive stable synchronized samples needed to accept a button state change (range 2..65535).
REQ-002 SHALL have parameter DECAY_CYCLES, default 1000000, the idle interval between automatic decrements (used only when LEVEL_DECAY_EN is defined).
REQ-003 SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1 bit, the reset; reset is asynchronous and active-low.
REQ-005 SHALL have port btn_up, input, 1 bit, the raw asynchronous increment button (active-high).
REQ-006 SHALL have port btn_down, input, 1 bit, the raw asynchronous decrement button (active-high).
REQ-007 SHALL have port level, output, 3 bits, the registered level that drives the downstream thermometer encoder's a input.
REQ-008 SHALL have port at_max, output, 1 bit, high while level == 7.
REQ-009 SHALL have port at_min, output, 1 bit, high while level == 0.
REQ-010 SHALL have port changed, output, 1 bit, a one-cycle pulse asserted in the cycle after level takes a new value.

Function
REQ-011 SHALL pass each button through a 2-flop synchronizer before any other logic.
REQ-012 SHALL debounce each synchronized button as follows:
- The per-button counter increments while the synchronized value differs from the debounced state, and clears otherwise.
- When the counter reaches DEBOUNCE_CYCLES, the debounced state flips and the counter clears.
REQ-013 SHALL generate a one-cycle press event on each debounced 0->1 transition; releases generate no event.
REQ-014 SHALL, on an up-only press event, increment level at the next clock edge, saturating at 7 (no wrap to 0).
REQ-015 SHALL, on a down-only press event, decrement level at the next clock edge, saturating at 0 (no wrap to 7).
REQ-016 SHALL leave level unchanged when up and down press events occur in the same cycle.
REQ-017 SHALL NOT assert changed for a saturated (blocked) step; changed is asserted only when level's value actually differs.
REQ-018 SHALL have a latency from the first clk edge sampling a stable raw press to the level update of 2 + DEBOUNCE_CYCLES + 1 cycles.
REQ-019 SHALL generate at_max and at_min combinationally from the level register only.
REQ-020 SHALL register exactly one step per held press; auto-repeat is not provided.

Reset
REQ-021 SHALL, while rst_n is low, asynchronously clear:
- level to 0, so at_min = 1 and at_max = 0;
- changed to 0;
- synchronizers, debounced states, counters and decay timer to 0.
REQ-022 SHALL, when reset is asserted mid-debounce, discard the pending press with no event after release.
REQ-023 SHALL, if a button is still held when reset releases, generate a press event after debounce completes, since the debounced state starts at 0.

Configuration
REQ-024 SHALL, with macro LEVEL_DECAY_EN defined, run an idle timer that clears on any press event and counts otherwise; at DECAY_CYCLES it decrements level by 1 (saturating at 0, changed pulses as per REQ-017) and restarts.
REQ-025 SHALL, with LEVEL_DECAY_EN undefined, omit the timer entirely and hold level indefinitely without presses.

Structure
REQ-026 SHALL take LEVEL_MAX (3'd7), LEVEL_MIN (3'd0) and LEVEL_W (3) from shared package level_pkg, which the thermometer-encoder test also uses.
REQ-027 SHALL implement synchronizer, debounce and rise detect in sub-module btn_debounce (ports clk, rst_n, raw, pressed), instantiated twice.

Verification (DEBOUNCE_CYCLES=4, DECAY_CYCLES=20)
REQ-028 SHALL cover a clean up press: btn_up held 10 cycles -> level 0->1 exactly 7 cycles after the first sampling edge, changed high for 1 cycle.
REQ-029 SHALL cover bounce: btn_up toggling every 2 cycles for 12 cycles, then low -> level stays 0 and changed never asserts.
REQ-030 SHALL cover saturation: 9 up presses -> level reaches 7, at_max = 1, and the 8th and 9th presses give no changed pulse; 9 down presses then -> level 0, at_min = 1.
REQ-031 SHALL cover simultaneous presses: btn_up and btn_down rising on the same edge at level 3 -> level stays 3 and changed stays 0.
REQ-032 SHALL cover mid-reset: rst_n pulsed low for 1 cycle during the 3rd debounce cycle of an up press -> level 0, no event after release.
REQ-033 SHALL cover decay (LEVEL_DECAY_EN defined): level 2 with no input -> level 1 after 20 idle cycles, 0 after 40, and stays 0 thereafter.
